// File: rtl/wiz_bus_sequencer.sv
// Clocked QL-bus to W5300 glue: decodes card accesses, sequences W5300 strobes
// with programmable timing, generates DTACK and owns the W5300 reset pulse.
module wiz_bus_sequencer #(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 2,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RST_LOW_CYC  = 100,
    parameter int unsigned RST_WAIT_CYC = 200000,
    parameter int unsigned CNT_W        = 20
) (
    input  logic       clk,
    input  logic       resetl,
    input  logic [9:0] address,
    input  logic       asl,
    input  logic       dsl,
    input  logic       rdwl,
    output logic       dtackl,
    output logic       dsmcl,
    output logic       dbenl,
    output logic       dbdir,
    output logic       wizcsl,
    output logic       wizrdl,
    output logic       wizwrl,
    output logic       wizrstl,
    output logic       busy
);

    localparam int unsigned SETUP_N    = (SETUP_CYC == 0)    ? 1 : SETUP_CYC;
    localparam int unsigned STROBE_N   = (STROBE_CYC == 0)   ? 1 : STROBE_CYC;
    localparam int unsigned HOLD_N     = (HOLD_CYC == 0)     ? 1 : HOLD_CYC;
    localparam int unsigned RST_LOW_N  = (RST_LOW_CYC == 0)  ? 1 : RST_LOW_CYC;
    localparam int unsigned RST_WAIT_N = (RST_WAIT_CYC == 0) ? 1 : RST_WAIT_CYC;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SETUP     = 4'd1;
    localparam logic [3:0] S_STROBE    = 4'd2;
    localparam logic [3:0] S_ACK       = 4'd3;
    localparam logic [3:0] S_HOLD      = 4'd4;
    localparam logic [3:0] S_DUMMY_ACK = 4'd5;
    localparam logic [3:0] S_RST_ACK   = 4'd6;
    localparam logic [3:0] S_RST_LOW   = 4'd7;
    localparam logic [3:0] S_RST_WAIT  = 4'd8;

    logic [1:0]       as_sync;
    logic [1:0]       ds_sync;
    logic             as_s;
    logic             ds_s;
    logic             card;
    logic             wiz_hit;
    logic             rst_hit;
    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rd_lat;
    logic             rd_nxt;
    logic             dtack_on;
    logic             access;
    logic             cs_nxt;
    logic             rdl_nxt;
    logic             wrl_nxt;
    logic             dben_nxt;
    logic             rstl_nxt;
    logic             dtack_nxt;
    logic             busy_nxt;
    logic             cnt_last;
    logic             strobe_on;

    assign as_s     = as_sync[1];
    assign ds_s     = ds_sync[1];
    assign access   = as_s && ds_s;
    assign cnt_last = (cnt <= CNT_W'(1));

    assign card    = (address[9:8] == 2'b11) && (address[7:4] == 4'b0010);
    assign wiz_hit = card && (address[3:0] == 4'd0);
    assign rst_hit = card && (address[3:0] == 4'd4) && !rdwl;

    // Motherboard disable must not wait for the synchronisers.
    assign dsmcl  = (card && !asl && !dsl) ? 1'b1 : 1'bz;
    assign dtackl = dtack_on ? 1'b0 : 1'bz;
    assign dbdir  = rd_lat;

    always_ff @(posedge clk) begin
        if (!resetl) begin
            as_sync  <= 2'b00;
            ds_sync  <= 2'b00;
            state    <= S_RST_LOW;
            cnt      <= CNT_W'(RST_LOW_N);
            rd_lat   <= 1'b1;
            wizcsl   <= 1'b1;
            wizrdl   <= 1'b1;
            wizwrl   <= 1'b1;
            dbenl    <= 1'b1;
            wizrstl  <= 1'b0;
            dtack_on <= 1'b0;
            busy     <= 1'b1;
        end else begin
            as_sync  <= {as_sync[0], ~asl};
            ds_sync  <= {ds_sync[0], ~dsl};
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rd_lat   <= rd_nxt;
            wizcsl   <= cs_nxt;
            wizrdl   <= rdl_nxt;
            wizwrl   <= wrl_nxt;
            dbenl    <= dben_nxt;
            wizrstl  <= rstl_nxt;
            dtack_on <= dtack_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next state plus outputs decoded from the next state, so each output
    // flop matches the state it belongs to.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_nxt    = rd_lat;
        case (state)
            S_IDLE: begin
                if (access && card) begin
                    rd_nxt = rdwl;
                    if (wiz_hit) begin
                        state_nxt = S_SETUP;
                        cnt_nxt   = CNT_W'(SETUP_N);
                    end else if (rst_hit) begin
                        state_nxt = S_RST_ACK;
                    end else begin
                        state_nxt = S_DUMMY_ACK;
                    end
                end
            end
            S_SETUP: begin
                if (!access) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = CNT_W'(HOLD_N);
                end else if (cnt_last) begin
                    state_nxt = S_STROBE;
                    cnt_nxt   = CNT_W'(STROBE_N);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (!access) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = CNT_W'(HOLD_N);
                end else if (cnt_last) begin
                    state_nxt = S_ACK;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_ACK: begin
                if (!ds_s) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = CNT_W'(HOLD_N);
                end
            end
            S_HOLD: begin
                if (cnt_last) state_nxt = S_IDLE;
                else          cnt_nxt   = cnt - CNT_W'(1);
            end
            S_DUMMY_ACK: begin
                if (!ds_s) state_nxt = S_IDLE;
            end
            S_RST_ACK: begin
                if (!ds_s) begin
                    state_nxt = S_RST_LOW;
                    cnt_nxt   = CNT_W'(RST_LOW_N);
                end
            end
            S_RST_LOW: begin
                if (cnt_last) begin
                    state_nxt = S_RST_WAIT;
                    cnt_nxt   = CNT_W'(RST_WAIT_N);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_RST_WAIT: begin
                if (cnt_last) state_nxt = S_IDLE;
                else          cnt_nxt   = cnt - CNT_W'(1);
            end
            default: state_nxt = S_IDLE;
        endcase

        strobe_on = (state_nxt == S_STROBE) || (state_nxt == S_ACK);
        cs_nxt    = !((state_nxt == S_SETUP) || strobe_on || (state_nxt == S_HOLD));
        rdl_nxt   = !(strobe_on && rd_nxt);
        wrl_nxt   = !(strobe_on && !rd_nxt);
        dben_nxt  = cs_nxt && (state_nxt != S_DUMMY_ACK);
        dtack_nxt = (state_nxt == S_ACK) || (state_nxt == S_DUMMY_ACK) ||
                    (state_nxt == S_RST_ACK);
        rstl_nxt  = (state_nxt != S_RST_LOW);
        busy_nxt  = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_wiz_bus_sequencer.sv
// Randomised scoreboard bench for wiz_bus_sequencer: expected acknowledges are
// queued at issue time and checked by an independent monitor.
module tb_wiz_bus_sequencer;

    localparam int S  = 1;
    localparam int T  = 2;
    localparam int H  = 1;
    localparam int RL = 4;
    localparam int RW = 8;

    typedef struct {
        int   kind;   // 0 wiz, 1 dummy, 2 reset write
        int   due;
        logic rd;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetl = 1'b0;
    logic [9:0] address = 10'h000;
    logic       asl = 1'b1;
    logic       dsl = 1'b1;
    logic       rdwl = 1'b1;
    wire        dtackl;
    wire        dsmcl;
    logic       dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl, busy;

    pullup(dtackl);
    pulldown(dsmcl);

    wiz_bus_sequencer #(
        .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H),
        .RST_LOW_CYC(RL), .RST_WAIT_CYC(RW), .CNT_W(20)
    ) dut (
        .clk(clk), .resetl(resetl), .address(address), .asl(asl), .dsl(dsl),
        .rdwl(rdwl), .dtackl(dtackl), .dsmcl(dsmcl), .dbenl(dbenl),
        .dbdir(dbdir), .wizcsl(wizcsl), .wizrdl(wizrdl), .wizwrl(wizwrl),
        .wizrstl(wizrstl), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   idle_edge = 0;
    int   last_rise = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic int model_kind(input logic [9:0] a, input logic rd);
        if (a[9:4] != 6'b110010) return -1;
        if (a[3:0] == 4'd0) return 0;
        if (a[3:0] == 4'd4 && !rd) return 2;
        return 1;
    endfunction

    // Monitor: bus invariants every cycle, scoreboard check on each DTACK.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("strobe_excl", 32'(!wizrdl && !wizwrl), 0);
                chk("strobe_no_cs", 32'((!wizrdl || !wizwrl) && wizcsl), 0);
                if (dtackl === 1'b0 && prev) begin
                    if (sb.size() == 0) begin
                        chk("spurious_dtack", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("dtack_cycle", cyc, e.due);
                        chk("dbdir", dbdir, e.rd);
                        if (e.kind == 0) begin
                            chk("ack_cs", wizcsl, 0);
                            chk("ack_dben", dbenl, 0);
                            chk("ack_rdl", wizrdl, e.rd ? 0 : 1);
                            chk("ack_wrl", wizwrl, e.rd ? 1 : 0);
                        end else begin
                            chk("nowiz_cs", wizcsl, 1);
                            chk("nowiz_strobes", 32'({wizrdl, wizwrl}), 3);
                            chk("nowiz_dben", dbenl, (e.kind == 1) ? 0 : 1);
                        end
                    end
                end
                prev = (dtackl !== 1'b0);
            end
        end
    end

    task automatic access(input logic [9:0] a, input logic rd);
        int   n, r, kind, dec;
        exp_t e;
        bit   got;
        @(negedge clk);
        address = a; rdwl = rd; asl = 1'b0; dsl = 1'b0; n = cyc;
        #1 chk("dsmcl_on", dsmcl, 1);
        kind = model_kind(a, rd);
        dec = (n + 3 > idle_edge + 1) ? n + 3 : idle_edge + 1;
        e.kind = kind; e.rd = rd; e.due = dec + ((kind == 0) ? S + T : 0);
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (dtackl === 1'b0) got = 1'b1;
        end
        chk("dtack_seen", got, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        asl = 1'b1; dsl = 1'b1; r = cyc; last_rise = r;
        case (kind)
            0:       idle_edge = r + 3 + H;
            2:       idle_edge = r + 3 + RL + RW;
            default: idle_edge = r + 3;
        endcase
        if (kind == 0) begin
            wait_cyc(r + 3);
            chk("hold_cs_low", wizcsl, 0);
            chk("hold_strobes_off", 32'({wizrdl, wizwrl}), 3);
            chk("hold_dtack_off", dtackl, 1);
            wait_cyc(r + 3 + H);
            chk("cs_release", wizcsl, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int p, n, off, pick;
        logic rd;
        exp_t e;
        bit got;

        // Power-up reset
        @(negedge clk);
        wait_cyc(1);
        chk("rst_wizrstl", wizrstl, 0);
        chk("rst_wizcsl", wizcsl, 1);
        chk("rst_strobes", 32'({wizrdl, wizwrl}), 3);
        chk("rst_dbenl", dbenl, 1);
        chk("rst_dbdir", dbdir, 1);
        chk("rst_dtackl", dtackl, 1);
        chk("rst_busy", busy, 1);
        wait_cyc(3);
        resetl = 1'b1; p = cyc;
        wait_cyc(p + RL - 1); chk("pwr_rstl_low", wizrstl, 0);
        wait_cyc(p + RL);     chk("pwr_rstl_high", wizrstl, 1);
        wait_cyc(p + RL + RW - 1); chk("pwr_busy", busy, 1);
        wait_cyc(p + RL + RW);     chk("pwr_idle", busy, 0);
        idle_edge = p + RL + RW;

        // Off-card access: ignored entirely
        @(negedge clk);
        address = 10'h100; rdwl = 1'b1; asl = 1'b0; dsl = 1'b0;
        #1 chk("offcard_dsmcl", dsmcl, 0);
        repeat (8) @(negedge clk);
        chk("offcard_busy", busy, 0);
        chk("offcard_dtack", dtackl, 1);
        asl = 1'b1; dsl = 1'b1;
        repeat (3) @(negedge clk);

        access(10'h320, 1'b1);
        access(10'h320, 1'b0);
        access(10'h328, 1'b1);
        repeat (3) @(negedge clk);

        // Abort during STROBE: no DTACK may follow
        @(negedge clk);
        address = 10'h320; rdwl = 1'b1; asl = 1'b0; dsl = 1'b0; n = cyc;
        wait_cyc(n + 3);
        chk("abort_setup_cs", wizcsl, 0);
        asl = 1'b1; dsl = 1'b1;
        wait_cyc(n + 5);
        chk("abort_in_strobe", wizrdl, 0);
        wait_cyc(n + 6);
        chk("abort_hold_rdl", wizrdl, 1);
        chk("abort_dtack", dtackl, 1);
        wait_cyc(n + 6 + H);
        chk("abort_cs_release", wizcsl, 1);
        idle_edge = n + 6 + H;
        repeat (6) @(negedge clk);

        // Software reset, then an access stalled in RST_WAIT
        access(10'h324, 1'b0);
        wait_cyc(last_rise + 3);           chk("swrst_low_start", wizrstl, 0);
        wait_cyc(last_rise + 3 + RL - 1);  chk("swrst_low_end", wizrstl, 0);
        wait_cyc(last_rise + 3 + RL);      chk("swrst_release", wizrstl, 1);
        chk("swrst_busy", busy, 1);
        access(10'h320, 1'b1);
        repeat (4) @(negedge clk);

        // Randomised mix of W5300, dummy and reset accesses
        for (int k = 0; k < 24; k++) begin
            pick = $urandom_range(0, 3);
            rd = 1'($urandom_range(0, 1));
            if (pick == 2) begin
                off = $urandom_range(1, 15);
                if (off == 4 && $urandom_range(0, 3) != 0) rd = 1'b1;
                access(10'h320 | 10'(off), rd);
            end else begin
                access(10'h320, rd);
            end
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        wait_cyc(idle_edge + 2);

        // resetl asserted while DTACK is being driven
        @(negedge clk);
        address = 10'h320; rdwl = 1'b1; asl = 1'b0; dsl = 1'b0; n = cyc;
        e.kind = 0; e.rd = 1'b1;
        e.due = ((n + 3 > idle_edge + 1) ? n + 3 : idle_edge + 1) + S + T;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (dtackl === 1'b0) got = 1'b1;
        end
        chk("ack_before_reset", got, 1);
        resetl = 1'b0;
        @(negedge clk);
        chk("midrst_strobes", 32'({wizrdl, wizwrl}), 3);
        chk("midrst_cs", wizcsl, 1);
        chk("midrst_dtack", dtackl, 1);
        chk("midrst_wizrstl", wizrstl, 0);
        asl = 1'b1; dsl = 1'b1; resetl = 1'b1; p = cyc;
        idle_edge = p + RL + RW;
        wait_cyc(idle_edge - 1); chk("midrst_busy", busy, 1);
        wait_cyc(idle_edge);     chk("midrst_idle", busy, 0);
        access(10'h320, 1'b0);

        repeat (10) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
